// File: rtl/seq_add_ctrl_if.sv
// Start/ready/done bus between a requesting datapath and seq_add_ctrl.
// Optional subtract signals (sub, ovf) exist only when SEQ_ADD_SUB_EN is defined.
interface seq_add_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SEQ_ADD_SUB_EN
    logic             sub;
    logic             ovf;

    modport master (
        output start, a, b, cin, sub,
        input  ready, busy, done, sum, cout, ovf
    );
    modport slave (
        input  start, a, b, cin, sub,
        output ready, busy, done, sum, cout, ovf
    );
`else
    modport master (
        output start, a, b, cin,
        input  ready, busy, done, sum, cout
    );
    modport slave (
        input  start, a, b, cin,
        output ready, busy, done, sum, cout
    );
`endif
endinterface

// File: rtl/seq_add_ctrl.sv
// Wide adder built by sequencing one 4-bit ripple-carry adder over WIDTH/4 slices, LSB first.
// Latency: NSLICE RUN cycles plus one DONE cycle; start is only accepted while ready=1.
// Macro SEQ_ADD_SUB_EN adds the sub input and ovf output (a-b with two's-complement overflow).
module rca (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_ci,
    output logic [3:0] o_s,
    output logic       o_co
);
    logic w_c;

    always_comb begin
        w_c = i_ci;
        o_s = '0;
        for (int i = 0; i < 4; i++) begin
            o_s[i] = i_a[i] ^ i_b[i] ^ w_c;
            w_c    = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
        end
        o_co = w_c;
    end
endmodule

module seq_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_add_ctrl_if.slave bus
);
    localparam int NSLICE = WIDTH / 4;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_accept;
    logic             w_ready;
    logic             w_busy;
    logic             w_done;
    logic             w_last;

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
`ifdef SEQ_ADD_SUB_EN
    logic             r_ovf;
`endif

    logic [3:0]       w_a_sl;
    logic [3:0]       w_b_sl;
    logic [3:0]       w_rca_s;
    logic             w_rca_co;

    assign w_last = (r_cnt == CW'(NSLICE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_ready  = 1'b0;
        w_busy   = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (bus.start) begin
                    w_accept = 1'b1;
                    w_next   = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Mux the active slice of the latched operands onto the shared adder.
    always_comb begin
        w_a_sl = '0;
        w_b_sl = '0;
        for (int s = 0; s < NSLICE; s++) begin
            if (r_cnt == CW'(s)) begin
                w_a_sl = r_a[4*s +: 4];
                w_b_sl = r_b[4*s +: 4];
            end
        end
    end

    rca u_rca (
        .i_a  (w_a_sl),
        .i_b  (w_b_sl),
        .i_ci (r_carry),
        .o_s  (w_rca_s),
        .o_co (w_rca_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
`ifdef SEQ_ADD_SUB_EN
            r_ovf   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_cnt <= '0;
            r_a   <= bus.a;
`ifdef SEQ_ADD_SUB_EN
            // Subtraction is a + ~b + 1, so cin is irrelevant when sub=1.
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub | bus.cin;
`else
            r_b     <= bus.b;
            r_carry <= bus.cin;
`endif
        end else if (r_state == S_RUN) begin
            for (int s = 0; s < NSLICE; s++) begin
                if (r_cnt == CW'(s)) begin
                    r_sum[4*s +: 4] <= w_rca_s;
                end
            end
            r_carry <= w_rca_co;
            if (w_last) begin
                r_cout <= w_rca_co;
`ifdef SEQ_ADD_SUB_EN
                r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_rca_s[3] != r_a[WIDTH-1]);
`endif
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.ready = w_ready;
    assign bus.busy  = w_busy;
    assign bus.done  = w_done;
    assign bus.sum   = r_sum;
    assign bus.cout  = r_cout;
`ifdef SEQ_ADD_SUB_EN
    assign bus.ovf   = r_ovf;
`endif
endmodule

// File: tb/tb_seq_add_ctrl.sv
// Self-checking bench for seq_add_ctrl: directed cases plus randomized operations
// checked against an arithmetic reference model.
module tb_seq_add_ctrl;
    localparam int W  = 16;
    localparam int NS = W / 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    seq_add_ctrl_if #(.WIDTH(W)) sif ();

    seq_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
        logic [W-1:0] d;
        if (sub) begin
            d = a - b;
            return {(a >= b), d};
        end
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic cin, input logic sub);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = sub ? (sa - sb) : (sa + sb + longint'(cin));
        return (r > longint'((1 << (W - 1)) - 1)) || (r < -longint'(1 << (W - 1)));
    endfunction

    // Issue one request from IDLE and collect what the DUT does; callers compare.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, output int lat, output int busy_cyc,
                          output logic [W-1:0] s, output logic co, output logic ov,
                          output logic done_nxt, output logic rdy_nxt);
        @(negedge clk);
        sif.start = 1'b1;
        sif.a     = a;
        sif.b     = b;
        sif.cin   = cin;
`ifdef SEQ_ADD_SUB_EN
        sif.sub   = sub;
`else
        if (sub) $display("note: sub requested without SEQ_ADD_SUB_EN");
`endif
        @(posedge clk);
        @(negedge clk);
        sif.start = 1'b0;
        lat      = 1;
        busy_cyc = 0;
        while (!sif.done && lat < 20) begin
            if (sif.busy) busy_cyc++;
            sif.a   = W'($urandom);
            sif.b   = W'($urandom);
            sif.cin = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        s  = sif.sum;
        co = sif.cout;
`ifdef SEQ_ADD_SUB_EN
        ov = sif.ovf;
`else
        ov = 1'b0;
`endif
        @(negedge clk);
        done_nxt = sif.done;
        rdy_nxt  = sif.ready;
    endtask

    task automatic test_reset();
        checks++; if (sif.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", sif.ready); end
        checks++; if (sif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", sif.busy); end
        checks++; if (sif.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", sif.done); end
        checks++; if (sif.sum !== 16'h0000) begin errors++; $display("FAIL reset_sum: got %h expected 0000", sif.sum); end
        checks++; if (sif.cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", sif.cout); end
`ifdef SEQ_ADD_SUB_EN
        checks++; if (sif.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", sif.ovf); end
`endif
    endtask

    task automatic test_basic_add();
        int lat, bc; logic [W-1:0] s; logic co, ov, dn, rd;
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, lat, bc, s, co, ov, dn, rd);
        checks++; if (lat !== NS + 1) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, NS + 1); end
        checks++; if (bc !== NS) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected %0d", bc, NS); end
        checks++; if (s !== 16'h5555) begin errors++; $display("FAIL basic_sum: got %h expected 5555", s); end
        checks++; if (co !== 1'b0) begin errors++; $display("FAIL basic_cout: got %b expected 0", co); end
        checks++; if (dn !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b expected 0", dn); end
        checks++; if (rd !== 1'b1) begin errors++; $display("FAIL basic_ready_after: got %b expected 1", rd); end
        repeat (3) @(negedge clk);
        checks++; if (sif.sum !== 16'h5555) begin errors++; $display("FAIL basic_sum_hold: got %h expected 5555", sif.sum); end
    endtask

    task automatic test_carry_chain();
        int lat, bc; logic [W-1:0] s; logic co, ov, dn, rd;
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, bc, s, co, ov, dn, rd);
        checks++; if (s !== 16'h0000) begin errors++; $display("FAIL carry_sum: got %h expected 0000", s); end
        checks++; if (co !== 1'b1) begin errors++; $display("FAIL carry_cout: got %b expected 1", co); end
        run_op(16'h0000, 16'h0000, 1'b1, 1'b0, lat, bc, s, co, ov, dn, rd);
        checks++; if (s !== 16'h0001) begin errors++; $display("FAIL cin_sum: got %h expected 0001", s); end
        checks++; if (co !== 1'b0) begin errors++; $display("FAIL cin_cout: got %b expected 0", co); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a1, b1, a2, b2, s1, s2;
        int dones, cyc; int dc [2]; logic second;
        a1 = W'($urandom); b1 = W'($urandom);
        a2 = W'($urandom); b2 = W'($urandom);
        dones = 0; second = 1'b0; dc[0] = 0; dc[1] = 0; s1 = '0; s2 = '0;
        @(negedge clk);
        sif.start = 1'b1; sif.a = a1; sif.b = b1; sif.cin = 1'b0;
`ifdef SEQ_ADD_SUB_EN
        sif.sub = 1'b0;
`endif
        for (cyc = 1; cyc <= 40 && dones < 2; cyc++) begin
            @(negedge clk);
            if (sif.done) begin
                dc[dones] = cyc;
                if (dones == 0) s1 = sif.sum; else s2 = sif.sum;
                dones++;
                if (dones == 1) begin sif.a = a2; sif.b = b2; end
            end else if (sif.busy) begin
                if (dones == 1 && !second) begin second = 1'b1; sif.start = 1'b0; end
                sif.a = W'($urandom); sif.b = W'($urandom);
            end
        end
        sif.start = 1'b0;
        checks++; if (dones !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", dones); end
        checks++; if (dc[0] !== NS + 1) begin errors++; $display("FAIL b2b_first_done_cycle: got %0d expected %0d", dc[0], NS + 1); end
        checks++; if (dc[1] - dc[0] !== NS + 2) begin errors++; $display("FAIL b2b_spacing: got %0d expected %0d", dc[1] - dc[0], NS + 2); end
        checks++; if (s1 !== W'(ref_sum(a1, b1, 1'b0, 1'b0))) begin errors++; $display("FAIL b2b_sum1: got %h expected %h", s1, W'(ref_sum(a1, b1, 1'b0, 1'b0))); end
        checks++; if (s2 !== W'(ref_sum(a2, b2, 1'b0, 1'b0))) begin errors++; $display("FAIL b2b_sum2: got %h expected %h", s2, W'(ref_sum(a2, b2, 1'b0, 1'b0))); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        int lat, bc, seen; logic [W-1:0] s; logic co, ov, dn, rd;
        @(negedge clk);
        sif.start = 1'b1; sif.a = 16'hFFFF; sif.b = 16'hFFFF; sif.cin = 1'b0;
`ifdef SEQ_ADD_SUB_EN
        sif.sub = 1'b0;
`endif
        @(posedge clk);
        @(negedge clk);
        sif.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (sif.busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %b expected 1", sif.busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (sif.sum !== 16'h0000) begin errors++; $display("FAIL rst_async_sum: got %h expected 0000", sif.sum); end
        checks++; if (sif.cout !== 1'b0) begin errors++; $display("FAIL rst_async_cout: got %b expected 0", sif.cout); end
        checks++; if (sif.ready !== 1'b1) begin errors++; $display("FAIL rst_async_ready: got %b expected 1", sif.ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (sif.done) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rst_no_done: got %0d done pulses expected 0", seen); end
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, lat, bc, s, co, ov, dn, rd);
        checks++; if (s !== 16'h0100) begin errors++; $display("FAIL rst_after_sum: got %h expected 0100", s); end
        checks++; if (lat !== NS + 1) begin errors++; $display("FAIL rst_after_latency: got %0d expected %0d", lat, NS + 1); end
    endtask

    task automatic test_random();
        int lat, bc; logic [W-1:0] s, a, b; logic co, ov, dn, rd, cin, sub; logic [W:0] exp;
        for (int n = 0; n < 40; n++) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            if (n % 8 == 0) a = '1;
`ifdef SEQ_ADD_SUB_EN
            sub = 1'($urandom);
`else
            sub = 1'b0;
`endif
            run_op(a, b, cin, sub, lat, bc, s, co, ov, dn, rd);
            exp = ref_sum(a, b, cin, sub);
            checks++; if (s !== exp[W-1:0]) begin errors++; $display("FAIL rand_sum[%0d]: got %h expected %h", n, s, exp[W-1:0]); end
            checks++; if (co !== exp[W]) begin errors++; $display("FAIL rand_cout[%0d]: got %b expected %b", n, co, exp[W]); end
            checks++; if (lat !== NS + 1) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", n, lat, NS + 1); end
`ifdef SEQ_ADD_SUB_EN
            checks++; if (ov !== ref_ovf(a, b, cin, sub)) begin errors++; $display("FAIL rand_ovf[%0d]: got %b expected %b", n, ov, ref_ovf(a, b, cin, sub)); end
`endif
        end
    endtask

`ifdef SEQ_ADD_SUB_EN
    task automatic test_sub();
        int lat, bc; logic [W-1:0] s; logic co, ov, dn, rd;
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, lat, bc, s, co, ov, dn, rd);
        checks++; if (s !== 16'hFFFE) begin errors++; $display("FAIL sub1_sum: got %h expected fffe", s); end
        checks++; if (co !== 1'b0) begin errors++; $display("FAIL sub1_cout: got %b expected 0", co); end
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL sub1_ovf: got %b expected 0", ov); end
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, lat, bc, s, co, ov, dn, rd);
        checks++; if (s !== 16'h7FFF) begin errors++; $display("FAIL sub2_sum: got %h expected 7fff", s); end
        checks++; if (co !== 1'b1) begin errors++; $display("FAIL sub2_cout: got %b expected 1", co); end
        checks++; if (ov !== 1'b1) begin errors++; $display("FAIL sub2_ovf: got %b expected 1", ov); end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst_n     = 1'b0;
        sif.start = 1'b0;
        sif.a     = '0;
        sif.b     = '0;
        sif.cin   = 1'b0;
`ifdef SEQ_ADD_SUB_EN
        sif.sub   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic_add();
        test_carry_chain();
        test_back_to_back();
        test_reset_midrun();
`ifdef SEQ_ADD_SUB_EN
        test_sub();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_add_ctrl.md
# seq_add_ctrl

Multi-cycle wide adder controller that adds two WIDTH-bit operands by sequencing one shared 4-bit ripple-carry adder (`rca`) over WIDTH/4 slices, LSB slice first. The carry out of each slice is registered and fed back as the carry in of the next slice.

- Trades latency for area: one `rca` instance instead of WIDTH/4 chained instances.
- Sits between a requesting datapath and the `rca` datapath.
- Handshake is start/ready/done.

## Interface

Parameters:
- WIDTH, 16, operand/result width. Must be a multiple of 4 and ≥ 8. NSLICE = WIDTH/4.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request. Accepted only on a rising edge where ready=1.
- a  input  WIDTH  operand A. Sampled at the accept edge.
- b  input  WIDTH  operand B. Sampled at the accept edge.
- cin  input  1  carry into slice 0. Sampled at the accept edge.
- ready  output  1  high in IDLE only.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB slice.

Reset and clocking: one clock; reset is asynchronous and active-low.

## Operation

FSM states IDLE, RUN, DONE:
- IDLE: ready=1.
  - start=1 at an edge: latch a, b, cin into internal registers; clear slice counter cnt; go to RUN.
  - start=0: stay in IDLE.
- RUN: busy=1. Slice cnt of the latched operands and the carry register drive the `rca` inputs. Each edge:
  - Write the `rca` sum to sum[4*cnt+3:4*cnt].
  - Load the `rca` carry out into the carry register.
  - Increment cnt.
  - At the edge where cnt = NSLICE-1: also load cout from the `rca` carry out and go to DONE.
- DONE: done=1, ready=0, busy=0. Next edge: go to IDLE.

Data and counter rules:
- start is ignored outside IDLE. The latched operands are immune to input changes after the accept edge.
- The sum register changes slice by slice during RUN. It is guaranteed correct only from DONE onward.
- sum and cout hold their values through IDLE until the next accept edge.
- Arithmetic is unsigned modulo 2^WIDTH; cout is bit WIDTH of a+b+cin.
- cnt width is clog2(NSLICE). cnt never wraps past NSLICE-1.

## Timing

- Reset values: sum=0, cout=0, done=0, busy=0, ready=1. FSM in IDLE, cnt=0, carry register=0.
- Reset is asynchronous: on rst_n falling, all registers take their reset values immediately.
- Reset asserted mid-RUN or in DONE aborts the operation: no done pulse, sum and cout cleared.
- Latency: accept edge E0 → RUN edges E1…E_NSLICE → done high during the cycle after E_NSLICE → ready high after E_NSLICE+1.
  - WIDTH=16: done in cycle 5 (counting the cycle after E0 as cycle 1); next accept possible at E6.
- Throughput: one operation per NSLICE+2 cycles.
- start held high continuously: re-accepted at the first edge with ready=1.

## Configuration

Macro SEQ_ADD_SUB_EN.

When SEQ_ADD_SUB_EN is defined:
- Adds port sub (input, 1 bit, sampled at the accept edge).
- Adds port ovf (output, 1 bit, reset 0, updated at the same edge as cout, held until the next accept edge).
- With sub=1, b is latched bit-inverted and the slice-0 carry in is forced to 1; cin is ignored. Result is a−b modulo 2^WIDTH, and cout=1 means no borrow.
- ovf is two's-complement overflow: operand MSBs (a, effective b) are equal AND the sum MSB differs from them.
- With sub=0, the add behaviour is unchanged and ovf is still computed.

When SEQ_ADD_SUB_EN is undefined:
- Ports sub and ovf do not exist.
- The block is add-only, exactly as described above.

## Test plan

- Reset release, WIDTH=16: ready=1, busy=0, done=0, sum=0x0000, cout=0.
- a=0x1234, b=0x4321, cin=0, start pulse → busy for 4 cycles, done pulse in cycle 5, sum=0x5555, cout=0; ready high the following cycle.
- Carry chain across slices: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1. Then a=0x0000, b=0x0000, cin=1 → sum=0x0001, cout=0.
- start held high and a/b changed during RUN → result reflects the accept-edge values only. Exactly one done per accepted request; the second request is accepted on the cycle after DONE.
- rst_n pulsed low during the 2nd RUN cycle of a=0xFFFF, b=0xFFFF → no done, sum=0, cout=0, ready=1. A new request after reset completes correctly.
- SEQ_ADD_SUB_EN defined:
  - 0x0005−0x0007 → sum=0xFFFE, cout=0, ovf=0.
  - 0x8000−0x0001 → sum=0x7FFF, cout=1, ovf=1.
